// File: rtl/sysu_mux153_arbiter_if.sv
// Signal bundle between the round-robin arbiter, its four requesters and the 74LS153 it drives.
// The slave side is the arbiter; the master side is whoever raises requests and returns Y1/Y2.
interface sysu_mux153_arbiter_if;
   logic [3:0] req;
   logic       Y1;
   logic       Y2;
   logic       A;
   logic       B;
   logic       E1_n;
   logic       E2_n;
   logic [3:0] gnt;
   logic       busy;
   logic       sample_valid;
   logic [1:0] sample_ch;
   logic [1:0] sample_y;

   modport slave (
      input  req, Y1, Y2,
      output A, B, E1_n, E2_n, gnt, busy, sample_valid, sample_ch, sample_y
   );

   modport master (
      output req, Y1, Y2,
      input  A, B, E1_n, E2_n, gnt, busy, sample_valid, sample_ch, sample_y
   );
endinterface

// File: rtl/sysu_mux153_arbiter.sv
// Round-robin time-share controller for one 74LS153: grants one of four requesters at a time,
// inserts a one-cycle strobe-off gap between grants and captures {Y2,Y1} when each grant ends.
module sysu_mux153_arbiter #(
   parameter int DWELL = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   sysu_mux153_arbiter_if.slave        bus
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t     state, state_next;
   logic [1:0] idx, idx_next;
   logic [1:0] ptr, ptr_next;
   logic [3:0] cnt, cnt_next;
   logic       exit_grant;
   logic       win_found;
   logic [1:0] win_idx;

   logic [1:0] sel_q;
   logic       en_n_q;
   logic [3:0] gnt_q;
   logic       busy_q;
   logic       sample_valid_q;
   logic [1:0] sample_ch_q;
   logic [1:0] sample_y_q;

   // Round-robin search starting just after the last winner; the last winner itself is tried last.
   always_comb begin
      logic [1:0] cand;
      win_found = 1'b0;
      win_idx   = ptr;
      cand      = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + 2'(k);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      ptr_next   = ptr;
      cnt_next   = cnt;
      exit_grant = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_next = GRANT;
               idx_next   = win_idx;
               ptr_next   = win_idx;
               cnt_next   = 4'd1;
            end
         end
         GRANT: begin
            if (!bus.req[idx] || cnt == 4'(DWELL)) begin
               exit_grant = 1'b1;
               state_next = GAP;
               cnt_next   = 4'd0;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         GAP: begin
            if (win_found) begin
               state_next = GRANT;
               idx_next   = win_idx;
               ptr_next   = win_idx;
               cnt_next   = 4'd1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the pins switch on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= 2'd0;
         ptr            <= 2'd3;
         cnt            <= 4'd0;
         sel_q          <= 2'd0;
         en_n_q         <= 1'b1;
         gnt_q          <= 4'd0;
         busy_q         <= 1'b0;
         sample_valid_q <= 1'b0;
         sample_ch_q    <= 2'd0;
         sample_y_q     <= 2'd0;
      end else begin
         state          <= state_next;
         idx            <= idx_next;
         ptr            <= ptr_next;
         cnt            <= cnt_next;
         sel_q          <= idx_next;
         en_n_q         <= (state_next != GRANT);
         gnt_q          <= (state_next == GRANT) ? (4'b0001 << idx_next) : 4'd0;
         busy_q         <= (state_next != IDLE);
         sample_valid_q <= exit_grant;
         if (exit_grant) begin
            sample_ch_q <= idx;
            sample_y_q  <= {bus.Y2, bus.Y1};
         end
      end
   end

   assign bus.A            = sel_q[0];
   assign bus.B            = sel_q[1];
   assign bus.E1_n         = en_n_q;
   assign bus.E2_n         = en_n_q;
   assign bus.gnt          = gnt_q;
   assign bus.busy         = busy_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.sample_ch    = sample_ch_q;
   assign bus.sample_y     = sample_y_q;

endmodule
